// File: rtl/hamming_pkg.sv
// ---------------------------------------------------------------------------
// hamming_pkg
//   Shared Hamming(7,4) definitions for the encoder scheduler and any future
//   decoder/checker.
//   Contents:
//     DATA_W            data nibble width (4)
//     CW_W              codeword width (7)
//     hamming74_encode  nibble -> codeword, bit order [6:0] =
//                       {p0, p1, d0, p2, d1, d2, d3}
// ---------------------------------------------------------------------------
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CW_W   = 7;

    // p0 covers d0,d1,d3; p1 covers d0,d2,d3; p2 covers d1,d2,d3.
    // The output order is the classic position order 1..7 laid out MSB first,
    // so a decoder can read the syndrome directly as a bit position.
    function automatic logic [CW_W-1:0] hamming74_encode(input logic [DATA_W-1:0] data);
        logic p0;
        logic p1;
        logic p2;
        p0 = data[0] ^ data[1] ^ data[3];
        p1 = data[0] ^ data[2] ^ data[3];
        p2 = data[1] ^ data[2] ^ data[3];
        return {p0, p1, data[0], p2, data[1], data[2], data[3]};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. The search starts just after
//   the last granted index (ptr) and wraps, so the most recently served
//   requester has the lowest priority.
//   Ports:
//     req      [N-1:0]          request vector
//     ptr      [IDX_W-1:0]      index of the last granted requester
//     en                        0 forces no grant
//     gnt      [N-1:0]          one-hot grant (all zero when nothing granted)
//     gnt_idx  [IDX_W-1:0]      binary index of the grant (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        // Offsets 1..N visit every requester once, ending at ptr itself,
        // which makes the previous winner the last candidate.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/hamming_enc_scheduler.sv
// ---------------------------------------------------------------------------
// hamming_enc_scheduler
//   Shares one Hamming(7,4) encoder among N_REQ requesters. A round-robin
//   arbiter picks at most one requester per cycle; its nibble is encoded and
//   pushed into an output FIFO together with the requester index. The
//   downstream side drains the FIFO.
//
//   Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both 1. A source holds its data stable while valid
//   is high and ready is low. req_ready is combinational from req_valid,
//   the round-robin pointer, the registered FIFO count and enable; it never
//   depends on cw_ready, so a pop does not open a slot for a grant in the
//   same cycle.
//
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     enable                1 = grants allowed; 0 = no grants, FIFO drains
//     req_valid [N_REQ]     per-requester valid
//     req_data  [4*N_REQ]   nibble i at [4i+3:4i], bit 4i = d0
//     req_ready [N_REQ]     one-hot or zero grant
//     cw_valid              FIFO head valid
//     cw_data   [7]         codeword at FIFO head
//     cw_src    [SRC_W]     requester index of FIFO head
//     cw_ready              downstream accept
//     fifo_count            current occupancy
//     word_count [16]       codewords accepted since reset (wraps)
// ---------------------------------------------------------------------------
module hamming_enc_scheduler
    import hamming_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int SRC_W      = $clog2(N_REQ),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [DATA_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      cw_valid,
    output logic [CW_W-1:0]           cw_data,
    output logic [SRC_W-1:0]          cw_src,
    input  logic                      cw_ready,
    output logic [CNT_W-1:0]          fifo_count,
    output logic [15:0]               word_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Arbitration
    logic [SRC_W-1:0]  rr_ptr;
    logic              grant_en;
    logic [N_REQ-1:0]  gnt;
    logic [SRC_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] gnt_data;
    logic [CW_W-1:0]   gnt_cw;
    logic              push;
    logic              pop;

    // FIFO storage
    logic [CW_W-1:0]   mem_cw  [FIFO_DEPTH];
    logic [SRC_W-1:0]  mem_src [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Full is judged on the registered count only.
    assign grant_en = enable && (count < CNT_W'(FIFO_DEPTH));

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign push      = |(req_valid & gnt);

    // Select the granted nibble: base bit index is gnt_idx * 4.
    assign gnt_data  = req_data[{gnt_idx, 2'b00} +: DATA_W];
    assign gnt_cw    = hamming74_encode(gnt_data);

    assign cw_valid  = (count != '0);
    assign pop       = cw_valid && cw_ready;

    // Head read straight from the storage array; the entry cannot change
    // while it sits at the head, so the outputs stay stable under backpressure.
    assign cw_data    = mem_cw[rd_ptr];
    assign cw_src     = mem_src[rd_ptr];
    assign fifo_count = count;

    // Round-robin pointer: remembers the last winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= SRC_W'(N_REQ - 1);
        end else if (push) begin
            rr_ptr <= gnt_idx;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_cw[i]  <= '0;
                mem_src[i] <= '0;
            end
        end else if (push) begin
            mem_cw[wr_ptr]  <= gnt_cw;
            mem_src[wr_ptr] <= gnt_idx;
        end
    end

    // Pointers, occupancy and the accepted-word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            word_count <= '0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                word_count <= word_count + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_enc_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hamming_enc_scheduler
//   Self-checking bench for hamming_enc_scheduler (N_REQ=4, FIFO_DEPTH=4).
//   Inputs change 1 time unit after a rising edge; outputs are sampled 3
//   units after the rising edge. Expected codewords ({src, cw}) are queued
//   when a grant is expected and compared when the word reaches the head
//   and is popped.
// ---------------------------------------------------------------------------
module tb_hamming_enc_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        cw_valid;
    logic [6:0]  cw_data;
    logic [1:0]  cw_src;
    logic        cw_ready;
    logic [2:0]  fifo_count;
    logic [15:0] word_count;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [8:0] exp_w;

    hamming_enc_scheduler #(.N_REQ(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cw_valid   (cw_valid),
        .cw_data    (cw_data),
        .cw_src     (cw_src),
        .cw_ready   (cw_ready),
        .fifo_count (fifo_count),
        .word_count (word_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference encoder built from Hamming bit positions 1..7: parity bit at
    // position 2^k covers every position whose index has bit k set; data
    // lives at positions 3,5,6,7. Output bit [7-pos] holds position pos.
    function automatic logic [6:0] ref_encode(input logic [3:0] d);
        logic [7:0] pos;
        logic [6:0] cw;
        pos    = '0;
        pos[3] = d[0];
        pos[5] = d[1];
        pos[6] = d[2];
        pos[7] = d[3];
        for (int k = 0; k < 3; k++) begin
            logic par;
            par = 1'b0;
            for (int p = 3; p <= 7; p++)
                if (((p >> k) & 1) == 1) par = par ^ pos[p];
            pos[1 << k] = par;
        end
        for (int p = 1; p <= 7; p++) cw[7 - p] = pos[p];
        return cw;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        cw_ready  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        reset  = 1'b0;
        enable = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if (cw_valid !== 1'b0 || fifo_count !== 3'd0 || word_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_state cw_valid=%b fifo_count=%0d word_count=%0d exp 0/0/0",
                     cw_valid, fifo_count, word_count);
        end
        checks++;
        if (cw_data !== 7'h00 || cw_src !== 2'd0) begin
            failures++;
            $display("FAIL reset_head cw_data=%h cw_src=%0d exp 00/0", cw_data, cw_src);
        end
        @(posedge clk);
        #3;
        reset     = 1'b0;
        enable    = 1'b1;
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_priority req_ready=%b exp 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single_word();
        do_reset();
        cw_ready = 1'b1;
        tick();
        req_valid     = 4'b0001;
        req_data[3:0] = 4'hB;
        #2;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant req_ready=%b exp 0001", req_ready);
        end
        exp_q.push_back({2'd0, 7'h55});
        tick();
        req_valid = '0;
        #2;
        checks++;
        exp_w = exp_q.pop_front();
        if (cw_valid !== 1'b1 || {cw_src, cw_data} !== exp_w) begin
            failures++;
            $display("FAIL single_word valid=%b src=%0d data=%h exp src=%0d data=%h",
                     cw_valid, cw_src, cw_data, exp_w[8:7], exp_w[6:0]);
        end
        checks++;
        if (word_count !== 16'd1) begin
            failures++;
            $display("FAIL single_word_count got=%0d exp 1", word_count);
        end
        tick();
        #2;
        checks++;
        if (cw_valid !== 1'b0 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL single_drained cw_valid=%b fifo_count=%0d exp 0/0", cw_valid, fifo_count);
        end
    endtask

    task automatic test_encode_table();
        logic [3:0] order[16];
        logic [6:0] fixed_cw[4];
        int         n;
        order[0] = 4'h0; order[1] = 4'h1; order[2] = 4'h8; order[3] = 4'hF;
        fixed_cw[0] = 7'h00; fixed_cw[1] = 7'h70; fixed_cw[2] = 7'h69; fixed_cw[3] = 7'h7F;
        n = 4;
        for (int v = 0; v < 16; v++) begin
            if (v != 0 && v != 1 && v != 8 && v != 15) begin
                order[n] = 4'(v);
                n++;
            end
        end
        do_reset();
        cw_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            req_valid      = 4'b0100;
            req_data[11:8] = order[i];
            #2;
            if (i > 0) begin
                checks++;
                exp_w = exp_q.pop_front();
                if (cw_valid !== 1'b1 || {cw_src, cw_data} !== exp_w) begin
                    failures++;
                    $display("FAIL encode_table[%0d] valid=%b src=%0d data=%h exp src=%0d data=%h",
                             i - 1, cw_valid, cw_src, cw_data, exp_w[8:7], exp_w[6:0]);
                end
            end
            checks++;
            if (req_ready !== 4'b0100) begin
                failures++;
                $display("FAIL encode_grant[%0d] req_ready=%b exp 0100", i, req_ready);
            end
            if (i < 4) exp_q.push_back({2'd2, fixed_cw[i]});
            else       exp_q.push_back({2'd2, ref_encode(order[i])});
        end
        tick();
        req_valid = '0;
        #2;
        checks++;
        exp_w = exp_q.pop_front();
        if (cw_valid !== 1'b1 || {cw_src, cw_data} !== exp_w) begin
            failures++;
            $display("FAIL encode_table[15] valid=%b src=%0d data=%h exp src=%0d data=%h",
                     cw_valid, cw_src, cw_data, exp_w[8:7], exp_w[6:0]);
        end
        checks++;
        if (word_count !== 16'd16) begin
            failures++;
            $display("FAIL encode_word_count got=%0d exp 16", word_count);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] rr_data[4];
        logic [3:0] exp_g;
        int         gcnt[4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rr_data[i] = 4'($urandom_range(0, 15));
            gcnt[i]    = 0;
        end
        cw_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            req_valid = 4'hF;
            req_data  = {rr_data[3], rr_data[2], rr_data[1], rr_data[0]};
            #2;
            if (c > 0) begin
                checks++;
                exp_w = exp_q.pop_front();
                if (cw_valid !== 1'b1 || {cw_src, cw_data} !== exp_w) begin
                    failures++;
                    $display("FAIL rr_word[%0d] valid=%b src=%0d data=%h exp src=%0d data=%h",
                             c - 1, cw_valid, cw_src, cw_data, exp_w[8:7], exp_w[6:0]);
                end
            end
            exp_g = 4'b0001 << (c % 4);
            checks++;
            if (req_ready !== exp_g) begin
                failures++;
                $display("FAIL rr_grant[%0d] req_ready=%b exp %b", c, req_ready, exp_g);
            end
            for (int i = 0; i < 4; i++) if (req_ready[i] === 1'b1) gcnt[i]++;
            exp_q.push_back({2'(c % 4), ref_encode(rr_data[c % 4])});
        end
        tick();
        req_valid = '0;
        #2;
        checks++;
        exp_w = exp_q.pop_front();
        if (cw_valid !== 1'b1 || {cw_src, cw_data} !== exp_w) begin
            failures++;
            $display("FAIL rr_word[11] valid=%b src=%0d data=%h exp src=%0d data=%h",
                     cw_valid, cw_src, cw_data, exp_w[8:7], exp_w[6:0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gcnt[i] != 3) begin
                failures++;
                $display("FAIL rr_fairness req%0d grants=%0d exp 3", i, gcnt[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] bp_data[5];
        bp_data[0] = 4'h3; bp_data[1] = 4'hC; bp_data[2] = 4'h6;
        bp_data[3] = 4'h9; bp_data[4] = 4'hE;
        do_reset();
        cw_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            req_valid     = 4'b0010;
            req_data[7:4] = bp_data[c];
            #2;
            checks++;
            if (req_ready !== 4'b0010) begin
                failures++;
                $display("FAIL bp_fill_grant[%0d] req_ready=%b exp 0010", c, req_ready);
            end
            exp_q.push_back({2'd1, ref_encode(bp_data[c])});
        end
        tick();
        req_data[7:4] = bp_data[4];
        #2;
        checks++;
        if (req_ready !== 4'b0000 || fifo_count !== 3'd4) begin
            failures++;
            $display("FAIL bp_full req_ready=%b fifo_count=%0d exp 0000/4", req_ready, fifo_count);
        end
        tick();
        #2;
        checks++;
        if (req_ready !== 4'b0000 || cw_data !== ref_encode(bp_data[0]) || cw_src !== 2'd1) begin
            failures++;
            $display("FAIL bp_hold req_ready=%b src=%0d data=%h exp 0000 src=1 data=%h",
                     req_ready, cw_src, cw_data, ref_encode(bp_data[0]));
        end
        // One-cycle pop while full: the freed slot is not usable this cycle.
        tick();
        cw_ready = 1'b1;
        #2;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_pop_no_grant req_ready=%b exp 0000", req_ready);
        end
        checks++;
        exp_w = exp_q.pop_front();
        if (cw_valid !== 1'b1 || {cw_src, cw_data} !== exp_w) begin
            failures++;
            $display("FAIL bp_word[0] valid=%b src=%0d data=%h exp src=%0d data=%h",
                     cw_valid, cw_src, cw_data, exp_w[8:7], exp_w[6:0]);
        end
        tick();
        cw_ready = 1'b0;
        #2;
        checks++;
        if (req_ready !== 4'b0010 || fifo_count !== 3'd3) begin
            failures++;
            $display("FAIL bp_regrant req_ready=%b fifo_count=%0d exp 0010/3", req_ready, fifo_count);
        end
        exp_q.push_back({2'd1, ref_encode(bp_data[4])});
        tick();
        req_valid = '0;
        #2;
        checks++;
        if (fifo_count !== 3'd4) begin
            failures++;
            $display("FAIL bp_refull fifo_count=%0d exp 4", fifo_count);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            cw_ready = 1'b1;
            #2;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL bp_drain[%0d] queue empty, cw_data=%h", k, cw_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (cw_valid !== 1'b1 || {cw_src, cw_data} !== exp_w) begin
                    failures++;
                    $display("FAIL bp_drain[%0d] valid=%b src=%0d data=%h exp src=%0d data=%h",
                             k, cw_valid, cw_src, cw_data, exp_w[8:7], exp_w[6:0]);
                end
            end
        end
        tick();
        #2;
        checks++;
        if (cw_valid !== 1'b0 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL bp_empty cw_valid=%b fifo_count=%0d exp 0/0", cw_valid, fifo_count);
        end
    endtask

    task automatic test_enable_low();
        do_reset();
        cw_ready = 1'b0;
        tick();
        req_valid        = 4'b1000;
        req_data[15:12]  = 4'h5;
        #2;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL en_grant[0] req_ready=%b exp 1000", req_ready);
        end
        exp_q.push_back({2'd3, ref_encode(4'h5)});
        tick();
        req_data[15:12] = 4'hA;
        #2;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL en_grant[1] req_ready=%b exp 1000", req_ready);
        end
        exp_q.push_back({2'd3, ref_encode(4'hA)});
        tick();
        enable    = 1'b0;
        req_valid = 4'hF;
        #2;
        checks++;
        if (req_ready !== 4'b0000 || fifo_count !== 3'd2) begin
            failures++;
            $display("FAIL en_low_hold req_ready=%b fifo_count=%0d exp 0000/2", req_ready, fifo_count);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            cw_ready = 1'b1;
            #2;
            checks++;
            exp_w = exp_q.pop_front();
            if (req_ready !== 4'b0000 || cw_valid !== 1'b1 || {cw_src, cw_data} !== exp_w) begin
                failures++;
                $display("FAIL en_low_drain[%0d] req_ready=%b valid=%b src=%0d data=%h exp src=%0d data=%h",
                         k, req_ready, cw_valid, cw_src, cw_data, exp_w[8:7], exp_w[6:0]);
            end
        end
        tick();
        #2;
        checks++;
        if (cw_valid !== 1'b0 || fifo_count !== 3'd0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL en_low_empty cw_valid=%b fifo_count=%0d req_ready=%b exp 0/0/0000",
                     cw_valid, fifo_count, req_ready);
        end
        checks++;
        if (word_count !== 16'd2) begin
            failures++;
            $display("FAIL en_low_word_count got=%0d exp 2", word_count);
        end
        req_valid = '0;
        enable    = 1'b1;
    endtask

    task automatic test_async_reset();
        logic [3:0] d0;
        do_reset();
        cw_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            req_valid      = 4'b0100;
            req_data[11:8] = 4'(c + 1);
            #2;
        end
        tick();
        req_valid = '0;
        #2;
        checks++;
        if (fifo_count !== 3'd3 || word_count !== 16'd3) begin
            failures++;
            $display("FAIL ar_pre fifo_count=%0d word_count=%0d exp 3/3", fifo_count, word_count);
        end
        // Assert reset between edges: effect must be immediate.
        reset = 1'b1;
        #1;
        checks++;
        if (cw_valid !== 1'b0 || fifo_count !== 3'd0 || word_count !== 16'd0) begin
            failures++;
            $display("FAIL ar_immediate cw_valid=%b fifo_count=%0d word_count=%0d exp 0/0/0",
                     cw_valid, fifo_count, word_count);
        end
        checks++;
        if (cw_data !== 7'h00 || cw_src !== 2'd0) begin
            failures++;
            $display("FAIL ar_head cw_data=%h cw_src=%0d exp 00/0", cw_data, cw_src);
        end
        exp_q.delete();
        @(posedge clk);
        #3;
        reset     = 1'b0;
        d0        = 4'($urandom_range(0, 15));
        req_data  = {4'h7, 4'h6, 4'h5, d0};
        req_valid = 4'hF;
        cw_ready  = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL ar_first_grant req_ready=%b exp 0001", req_ready);
        end
        exp_q.push_back({2'd0, ref_encode(d0)});
        tick();
        req_valid = '0;
        #2;
        checks++;
        exp_w = exp_q.pop_front();
        if (cw_valid !== 1'b1 || {cw_src, cw_data} !== exp_w || word_count !== 16'd1) begin
            failures++;
            $display("FAIL ar_after valid=%b src=%0d data=%h wc=%0d exp src=%0d data=%h wc=1",
                     cw_valid, cw_src, cw_data, word_count, exp_w[8:7], exp_w[6:0]);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        cw_ready  = 1'b0;
        test_reset();
        test_single_word();
        test_encode_table();
        test_round_robin();
        test_backpressure();
        test_enable_low();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
